// File: rtl/matrix_column_loader.sv
// Streams a COLS-wide window of a host-written column buffer into a dot-matrix
// driver's load port. Optional free-running frame trigger: MATRIX_LOADER_AUTO_EN.
module matrix_column_loader #(
    parameter int COLS       = 32,
    parameter int ROWS       = 16,
    parameter int MSG_COLS   = 64,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int AUTO_DIV   = 1000000,
    localparam int AW        = $clog2(MSG_COLS),
    localparam int IDW       = $clog2(COLS)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic            SCROLL,
    input  logic            WR_EN,
    input  logic [AW-1:0]   WR_ADDR,
    input  logic [ROWS-1:0] WR_DATA,
    output logic [IDW-1:0]  column_id,
    output logic [ROWS-1:0] in_column,
    output logic            LOAD,
    output logic            BUSY,
    output logic            FRAME_DONE,
    output logic [AW-1:0]   OFFSET
);
    localparam int PW = 16;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  col_q, col_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   off_q, off_d;
    logic [IDW-1:0]  id_q;
    logic [ROWS-1:0] data_q;
    logic            load_q, busy_q, done_q;
    logic            latch;
    logic            start_any;
    logic [AW:0]     sum;
    logic [AW-1:0]   rd_addr;
    logic [ROWS-1:0] buf_q [MSG_COLS];

`ifdef MATRIX_LOADER_AUTO_EN
    localparam int DW = $clog2(AUTO_DIV + 1);
    logic [DW-1:0] div_q;
    logic          auto_start;

    assign auto_start = (div_q == DW'(AUTO_DIV - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)        div_q <= '0;
        else if (auto_start) div_q <= '0;
        else                 div_q <= div_q + 1'b1;
    end

    assign start_any = START | auto_start;
`else
    assign start_any = START;
`endif

    // Window index wraps by a single conditional subtract instead of a modulo.
    always_comb begin
        sum     = {1'b0, off_q} + (AW+1)'(col_d);
        rd_addr = (sum >= (AW+1)'(MSG_COLS)) ? AW'(sum - (AW+1)'(MSG_COLS)) : AW'(sum);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_any) begin
                    state_d = S_SETUP;
                    col_d   = '0;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == PW'(SETUP_CYC - 1)) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == PW'(STROBE_CYC - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == PW'(HOLD_CYC - 1)) begin
                    cnt_d = '0;
                    if (col_q == IDW'(COLS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        col_d   = col_q + 1'b1;
                        latch   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (SCROLL)
                    off_d = (off_q == AW'(MSG_COLS - 1)) ? '0 : off_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            if (latch) begin
                id_q   <= col_d;
                data_q <= buf_q[rd_addr];
            end
            // Outputs are registered from the next state so they never glitch.
            load_q <= (state_d == S_STROBE);
            busy_q <= (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
            done_q <= (state_d == S_DONE);
        end
    end

    // A write on the same edge as a column's sample is not seen by that column.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int j = 0; j < MSG_COLS; j++) buf_q[j] <= '0;
        end else if (WR_EN && (int'(WR_ADDR) < MSG_COLS)) begin
            buf_q[WR_ADDR] <= WR_DATA;
        end
    end

    assign column_id  = id_q;
    assign in_column  = data_q;
    assign LOAD       = load_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign OFFSET     = off_q;

endmodule

// File: tb/tb_matrix_column_loader.sv
// Scoreboard bench: stimulus queues expected (column_id, in_column) per LOAD rise,
// a negedge monitor pops and compares, and also checks per-column strobe timing.
module tb_matrix_column_loader;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        SCROLL = 1'b0;
    logic        WR_EN = 1'b0;
    logic [5:0]  WR_ADDR = '0;
    logic [15:0] WR_DATA = '0;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        LOAD, BUSY, FRAME_DONE;
    logic [5:0]  OFFSET;

    matrix_column_loader dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .SCROLL(SCROLL),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .column_id(column_id), .in_column(in_column), .LOAD(LOAD),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .OFFSET(OFFSET)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   loads = 0;
    bit   chk_timing = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor
    logic        load_prev = 1'b0;
    logic [20:0] last_pair = '0;
    logic [20:0] rise_pair = '0;
    int          stable = 0;
    int          hi_cnt = 0;

    always @(negedge CLK) begin
        if ({column_id, in_column} == last_pair) stable++;
        else stable = 1;
        last_pair = {column_id, in_column};
        if (RESET_N) begin
            if (LOAD && !load_prev) begin
                exp_t e;
                loads++;
                hi_cnt = 1;
                rise_pair = {column_id, in_column};
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_load: id %0d data 0x%0h with empty queue", column_id, in_column);
                end else begin
                    e = exp_q.pop_front();
                    check("column_id", {27'd0, column_id}, {27'd0, e.id});
                    check("in_column", {16'd0, in_column}, {16'd0, e.data});
                    if (chk_timing) check("setup_stable", stable, 3);
                end
            end else if (LOAD) begin
                hi_cnt++;
            end
            if (!LOAD && load_prev && chk_timing) begin
                check("strobe_len", hi_cnt, 2);
                check("hold_stable", {11'd0, column_id, in_column}, {11'd0, rise_pair});
            end
            if (FRAME_DONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        load_prev = LOAD;
    end

    task automatic push_frame(input int off, input bit zero);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.id   = 5'(i);
            e.data = zero ? 16'h0000 : 16'h0100 + 16'((off + i) % 64);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int d0, input int start_c);
        for (int t = 0; t < 400 && done_cnt == d0; t++) @(negedge CLK);
        if (done_cnt == d0) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout: no FRAME_DONE within 400 cycles");
        end else begin
            check("frame_latency", done_cyc - start_c, 160);
        end
    endtask

    task automatic run_frame(input int off, input bit scroll, input bit zero);
        int d0, start_c;
        push_frame(off, zero);
        SCROLL = scroll;
        d0 = done_cnt;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        start_c = cyc;
        check("busy_after_start", {31'd0, BUSY}, 32'd1);
        wait_done(d0, start_c);
        @(negedge CLK);
        SCROLL = 1'b0;
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int d0, l0, t;
        exp_t e;
        #1;
        check("rst_load", {31'd0, LOAD}, 0);
        check("rst_busy", {31'd0, BUSY}, 0);
        check("rst_done", {31'd0, FRAME_DONE}, 0);
        check("rst_offset", {26'd0, OFFSET}, 0);
        check("rst_col_id", {27'd0, column_id}, 0);
        check("rst_in_column", {16'd0, in_column}, 0);
        #20 RESET_N = 1'b1;

        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            WR_EN = 1'b1; WR_ADDR = 6'(i); WR_DATA = 16'h0100 + 16'(i);
        end
        @(negedge CLK) WR_EN = 1'b0;

        // Frame 1: content plus per-column timing
        chk_timing = 1'b1;
        run_frame(0, 1'b0, 1'b0);
        chk_timing = 1'b0;
        check("offset_no_scroll", {26'd0, OFFSET}, 0);

        // 40 scrolled frames
        for (int f = 0; f < 40; f++) run_frame(f, 1'b1, 1'b0);
        check("offset_after_40", {26'd0, OFFSET}, 40);

        // Offset 40: column 23 = buf[63], column 24 wraps to buf[0]
        run_frame(40, 1'b0, 1'b0);
        check("offset_hold", {26'd0, OFFSET}, 40);

        // Re-START mid-frame ignored; write colliding with column 0 sample not seen
        push_frame(40, 1'b0);
        d0 = done_cnt;
        l0 = loads;
        @(negedge CLK);
        START = 1'b1; WR_EN = 1'b1; WR_ADDR = 6'd40; WR_DATA = 16'hBEEF;
        @(negedge CLK);
        START = 1'b0; WR_EN = 1'b0;
        repeat (50) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK) START = 1'b0;
        t = 0;
        while (!FRAME_DONE && t < 400) begin @(negedge CLK); t++; end
        // START during DONE is also ignored
        START = 1'b1;
        @(negedge CLK) START = 1'b0;
        check("start_in_done_ignored", {31'd0, BUSY}, 0);
        repeat (200) @(negedge CLK);
        check("single_frame_done", done_cnt - d0, 1);
        check("exactly_32_loads", loads - l0, 32);
        check("queue_empty_restart", exp_q.size(), 0);

        // Reset mid-frame while LOAD high
        push_frame(40, 1'b0);
        exp_q[0].data = 16'hBEEF;
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        repeat (80) @(negedge CLK);
        t = 0;
        while (!LOAD && t < 10) begin @(negedge CLK); t++; end
        check("load_before_reset", {31'd0, LOAD}, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("async_load", {31'd0, LOAD}, 0);
        check("async_busy", {31'd0, BUSY}, 0);
        check("async_offset", {26'd0, OFFSET}, 0);
        check("async_col_id", {27'd0, column_id}, 0);
        check("async_in_column", {16'd0, in_column}, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (200) @(negedge CLK);
        check("no_done_after_abort", done_cnt - d0, 0);

        // Buffer cleared by reset
        run_frame(0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
